// File: rtl/pmu_pkg.sv
// Definitions shared between the PMU FSM and the memory/scan-chain scheduler:
// default datapath widths, the scheduler state encoding and the words-per-block rule.
package pmu_pkg;

  localparam int PMU_MEM_DATA_WIDTH = 32;
  localparam int PMU_MEM_ADDR_WIDTH = 8;
  localparam int PMU_AES_DATA_WIDTH = 128;
  localparam int PMU_AES_LATENCY    = 10;
  localparam int PMU_MEM_START_ADDR = 1;
  localparam int PMU_LEN_WIDTH      = 32;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] KICK    = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;
  localparam logic [2:0] LOAD    = 3'd5;
  localparam logic [2:0] SHIFT   = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  function automatic int sipo_count(input int aes_width, input int mem_width);
    return aes_width / mem_width;
  endfunction

endpackage

// File: rtl/mem_block_fetcher.sv
// Issues the NVM reads for one cipher block and assembles the returned words,
// word 0 in the MSBs. Read data arrives one cycle after its strobe.
module mem_block_fetcher
  import pmu_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = PMU_MEM_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = PMU_MEM_ADDR_WIDTH,
  parameter int AES_DATA_WIDTH = PMU_AES_DATA_WIDTH,
  parameter int MEM_START_ADDR = PMU_MEM_START_ADDR,
  parameter int LEN_WIDTH      = PMU_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_i,
  input  logic [LEN_WIDTH-1:0]      blk_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
  output logic                      mem_rd_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [AES_DATA_WIDTH-1:0] block_o,
  output logic                      fetch_done_o
);

  localparam int SIPO = sipo_count(AES_DATA_WIDTH, MEM_DATA_WIDTH);
  localparam int KW   = (SIPO > 1) ? $clog2(SIPO) : 1;

  logic [KW-1:0]             k;
  logic [KW-1:0]             k_q;
  logic                      rd_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_cur;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [AES_DATA_WIDTH-1:0] block_q;

  // The range check at start keeps this sum below 2^MEM_ADDR_WIDTH, so truncation is safe.
  assign addr_cur = MEM_ADDR_WIDTH'(MEM_START_ADDR)
                  + MEM_ADDR_WIDTH'(SIPO) * MEM_ADDR_WIDTH'(blk_i)
                  + MEM_ADDR_WIDTH'(k);

  assign fetch_done_o = fetch_i && (k == KW'(SIPO - 1));
  assign mem_rd_o     = fetch_i;
  assign mem_addr_o   = fetch_i ? addr_cur : addr_q;
  assign block_o      = block_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k       <= '0;
      k_q     <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      block_q <= '0;
    end else begin
      k    <= (fetch_i && !fetch_done_o) ? k + KW'(1) : '0;
      k_q  <= k;
      rd_q <= fetch_i;
      if (fetch_i) begin
        addr_q <= addr_cur;
      end
      // rd_q/k_q remember which slot the word on mem_data_i this cycle belongs to.
      for (int i = 0; i < SIPO; i++) begin
        if (rd_q && (k_q == KW'(i))) begin
          block_q[AES_DATA_WIDTH-1-MEM_DATA_WIDTH*i -: MEM_DATA_WIDTH] <= mem_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/mem_sc_scheduler.sv
// Sequencer for NVM -> inverse AES -> PISO -> scan chain, one 128-bit block at a time,
// with a start/done handshake towards the PMU FSM.
module mem_sc_scheduler
  import pmu_pkg::*;
#(
  parameter int MEM_DATA_WIDTH = PMU_MEM_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = PMU_MEM_ADDR_WIDTH,
  parameter int AES_DATA_WIDTH = PMU_AES_DATA_WIDTH,
  parameter int AES_LATENCY    = PMU_AES_LATENCY,
  parameter int MEM_START_ADDR = PMU_MEM_START_ADDR,
  parameter int LEN_WIDTH      = PMU_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      len_i,
  input  logic                      abort_i,
  output logic                      mem_rd_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
  output logic [AES_DATA_WIDTH-1:0] aes_data_o,
  output logic                      aes_valid_o,
  output logic                      piso_load_o,
  output logic                      piso_en_o,
  output logic                      sc_en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int SIPO    = sipo_count(AES_DATA_WIDTH, MEM_DATA_WIDTH);
  localparam int CW      = LEN_WIDTH + MEM_ADDR_WIDTH;
  localparam int CNT_MAX = (AES_DATA_WIDTH > AES_LATENCY) ? AES_DATA_WIDTH : AES_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [LEN_WIDTH-1:0] blk;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 err_q;
  logic                 fetch_done;
  logic [CW-1:0]        words_end;
  logic                 range_bad;

  // Widened so a huge len_i can never wrap into an apparently valid range.
  assign words_end = CW'(MEM_START_ADDR) + CW'(SIPO) * CW'(len_i);
  assign range_bad = words_end > (CW'(1) << MEM_ADDR_WIDTH);

  assign busy_o      = state inside {FETCH, CAPTURE, KICK, WAIT, LOAD, SHIFT};
  assign aes_valid_o = (state == KICK);
  assign piso_load_o = (state == LOAD);
  assign piso_en_o   = (state == SHIFT);
  assign sc_en_o     = (state == SHIFT);
  assign done_o      = (state == DONE);
  assign err_o       = err_q;

  mem_block_fetcher #(
    .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .AES_DATA_WIDTH (AES_DATA_WIDTH),
    .MEM_START_ADDR (MEM_START_ADDR),
    .LEN_WIDTH      (LEN_WIDTH)
  ) u_fetcher (
    .clk          (clk),
    .rst          (rst),
    .fetch_i      (state == FETCH),
    .blk_i        (blk),
    .mem_data_i   (mem_data_i),
    .mem_rd_o     (mem_rd_o),
    .mem_addr_o   (mem_addr_o),
    .block_o      (aes_data_o),
    .fetch_done_o (fetch_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (abort_i && busy_o) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (len_i == '0) begin
                state <= DONE;
              end else if (range_bad) begin
                err_q <= 1'b1;
              end else begin
                len_q <= len_i;
                blk   <= '0;
                state <= FETCH;
              end
            end
          end
          FETCH: begin
            if (fetch_done) state <= CAPTURE;
          end
          CAPTURE: state <= KICK;
          KICK: begin
            cnt   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (cnt == CNT_W'(AES_LATENCY - 1)) begin
              cnt   <= '0;
              state <= LOAD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LOAD: begin
            cnt   <= '0;
            state <= SHIFT;
          end
          SHIFT: begin
            if (cnt == CNT_W'(AES_DATA_WIDTH - 1)) begin
              cnt   <= '0;
              blk   <= blk + LEN_WIDTH'(1);
              state <= ((blk + LEN_WIDTH'(1)) < len_q) ? FETCH : DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_sc_scheduler.sv
// Self-checking bench for mem_sc_scheduler: start-decision table, directed corner
// sequences and randomized runs against a per-cycle schedule model.
module tb_mem_sc_scheduler;

  localparam int PER_BLK = 4 + 1 + 1 + 10 + 1 + 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  len_i;
  logic         abort_i;
  logic         mem_rd_o;
  logic [7:0]   mem_addr_o;
  logic [31:0]  mem_data_i;
  logic [127:0] aes_data_o;
  logic         aes_valid_o;
  logic         piso_load_o;
  logic         piso_en_o;
  logic         sc_en_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  mem [256];
  logic [7:0]   exp_addr_hold;
  logic [127:0] exp_aes;
  bit           aes_known;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    bit         valid;
    bit         load;
    bit         shift;
    bit         busy;
    bit         done;
    bit         err;
    bit         capture;
    int         blk;
  } exp_t;

  typedef struct {
    logic [31:0] len;
    bit          exp_err;
    bit          exp_done;
    bit          exp_busy;
  } vec_t;

  mem_sc_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .aes_data_o  (aes_data_o),
    .aes_valid_o (aes_valid_o),
    .piso_load_o (piso_load_o),
    .piso_en_o   (piso_en_o),
    .sc_en_o     (sc_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // NVM model: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_data_i <= mem_rd_o ? mem[mem_addr_o] : $urandom;

  // Expected behaviour t cycles after the start cycle (t=0), from the block schedule.
  function automatic exp_t model(input int t, input longint len, input int abort_at);
    exp_t e;
    int u, b, r;
    e = '{default: 0};
    if (t == 0) return e;
    if (abort_at >= 0 && t > abort_at) return e;
    if (len == 0) begin
      e.done = (t == 1);
      return e;
    end
    if (1 + 4 * len > 256) begin
      e.err = (t == 1);
      return e;
    end
    u = t - 1;
    b = u / PER_BLK;
    r = u % PER_BLK;
    if (b < len) begin
      e.busy = 1;
      e.blk  = b;
      if (r < 4) begin
        e.rd   = 1;
        e.addr = 8'(1 + 4 * b + r);
      end else if (r == 4) e.capture = 1;
      else if (r == 5)     e.valid   = 1;
      else if (r == 16)    e.load    = 1;
      else if (r >= 17)    e.shift   = 1;
    end else if (longint'(u) == PER_BLK * len) begin
      e.done = 1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] outs_vec();
    return {mem_rd_o, mem_addr_o, aes_valid_o, piso_load_o, piso_en_o, sc_en_o,
            busy_o, done_o, err_o};
  endfunction

  task automatic applyStimulus(input longint len, input int abort_at, input bit noisy);
    exp_t e;
    int   done_t, last_act, total;
    bit   accepted;
    int   ce[5];
    int   ca[5];
    accepted = (len != 0) && (1 + 4 * len <= 256);
    done_t   = accepted ? int'(1 + PER_BLK * len) : 1;
    last_act = (abort_at >= 0) ? abort_at : done_t;
    total    = last_act + 3;
    for (int i = 0; i < 5; i++) begin
      ce[i] = 0;
      ca[i] = 0;
    end
    for (int t = 0; t < total; t++) begin
      start   = (t == 0) || (noisy && accepted && t >= 1 && t <= last_act &&
                             $urandom_range(0, 3) == 0);
      len_i   = (t == 0) ? 32'(len) : $urandom;
      abort_i = (t == abort_at);
      @(negedge clk);
      e = model(t, len, abort_at);
      if (e.rd) exp_addr_hold = e.addr;
      if (e.rd || e.capture) aes_known = 0;
      if (e.valid) begin
        exp_aes   = {mem[1 + 4 * e.blk], mem[2 + 4 * e.blk], mem[3 + 4 * e.blk], mem[4 + 4 * e.blk]};
        aes_known = 1;
      end
      checkOutput($sformatf("outs len=%0d t=%0d", len, t), 128'(outs_vec()),
                  128'({e.rd, exp_addr_hold, e.valid, e.load, e.shift, e.shift,
                        e.busy, e.done, e.err}));
      if (aes_known) checkOutput($sformatf("aes_data len=%0d t=%0d", len, t), aes_data_o, exp_aes);
      ce[0] += int'(e.rd);    ca[0] += int'(mem_rd_o);
      ce[1] += int'(e.valid); ca[1] += int'(aes_valid_o);
      ce[2] += int'(e.load);  ca[2] += int'(piso_load_o);
      ce[3] += int'(e.shift); ca[3] += int'(sc_en_o);
      ce[4] += int'(e.done);  ca[4] += int'(done_o);
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    abort_i = 1'b0;
    checkOutput("count mem_rd",    128'(ca[0]), 128'(ce[0]));
    checkOutput("count aes_valid", 128'(ca[1]), 128'(ce[1]));
    checkOutput("count piso_load", 128'(ca[2]), 128'(ce[2]));
    checkOutput("count sc_en",     128'(ca[3]), 128'(ce[3]));
    checkOutput("count done",      128'(ca[4]), 128'(ce[4]));
  endtask

  task automatic fillRandomMem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  vec_t vecs[8];

  initial begin
    longint rlen;
    int     rab;
    int     sel;

    vecs[0] = '{32'd0,          1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'd1,          1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'd63,         1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'd64,         1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'd65,         1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h4000_0000,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'hC000_0001,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};

    fillRandomMem();
    rst     = 1'b0;
    start   = 1'b0;
    len_i   = '0;
    abort_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outs", 128'(outs_vec()), 128'(0));
    checkOutput("reset aes_data", aes_data_o, 128'(0));
    rst = 1'b1;
    exp_addr_hold = 8'd0;
    exp_aes       = '0;
    aes_known     = 1;
    @(posedge clk);
    #1;

    // Start decisions: range check, zero length, accepted (then aborted).
    foreach (vecs[i]) begin
      start   = 1'b1;
      len_i   = vecs[i].len;
      abort_i = 1'b0;
      @(posedge clk);
      #1;
      start   = 1'b0;
      abort_i = vecs[i].exp_busy;
      @(negedge clk);
      checkOutput($sformatf("start decision len=%h {err,done,busy,rd}", vecs[i].len),
                  128'({err_o, done_o, busy_o, mem_rd_o}),
                  128'({vecs[i].exp_err, vecs[i].exp_done, vecs[i].exp_busy, vecs[i].exp_busy}));
      if (vecs[i].exp_busy) begin
        exp_addr_hold = 8'd1;
        aes_known     = 0;
      end
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      @(posedge clk);
      #1;
    end

    // Single block with known words.
    mem[1] = 32'h0011_2233;
    mem[2] = 32'h4455_6677;
    mem[3] = 32'h8899_AABB;
    mem[4] = 32'hCCDD_EEFF;
    applyStimulus(1, -1, 0);
    checkOutput("single block aes_data", aes_data_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    fillRandomMem();
    applyStimulus(3, -1, 1);
    applyStimulus(0, -1, 0);
    applyStimulus(64, -1, 0);

    // Abort at shift cycle 50 of block 0, then a clean restart from address 1.
    applyStimulus(2, 1 + 17 + 50, 1);
    applyStimulus(1, -1, 0);

    // Asynchronous reset in the middle of FETCH (k=2).
    start = 1'b1;
    len_i = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("fetch k2 before reset {rd,addr}", 128'({mem_rd_o, mem_addr_o}), 128'({1'b1, 8'd3}));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset outs", 128'(outs_vec()), 128'(0));
    checkOutput("async reset aes_data", aes_data_o, 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_addr_hold = 8'd0;
    exp_aes       = '0;
    aes_known     = 1;
    @(posedge clk);
    #1;
    fillRandomMem();
    applyStimulus(1, -1, 0);

    // Randomized runs.
    for (int n = 0; n < 8; n++) begin
      fillRandomMem();
      sel = $urandom_range(0, 9);
      if (sel == 0)      rlen = longint'($urandom_range(64, 300));
      else if (sel == 1) rlen = 0;
      else               rlen = longint'($urandom_range(1, 3));
      rab = -1;
      if (rlen >= 1 && rlen <= 3 && $urandom_range(0, 2) == 0)
        rab = $urandom_range(1, PER_BLK * int'(rlen));
      applyStimulus(rlen, rab, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sc_scheduler.md
Name: mem_sc_scheduler

Overview:
Sequencer for the NVM -> inverse-AES -> PISO -> scan-chain datapath, used by the secure power-up load path. It takes a block count from the bootloader and, for each 128-bit block, does the following in order: fetches SIPO_MEM_COUNT words from nv_memory, presents the block to inv_aes_128, waits the AES latency, loads the PISO, and gates the scan chain for exactly AES_DATA_WIDTH shift cycles. The PMU FSM instantiates it and replaces its hand-counted state four with a start/done handshake.

Parameters:
MEM_DATA_WIDTH, 32, NVM word width
MEM_ADDR_WIDTH, 8, NVM address width
AES_DATA_WIDTH, 128, cipher block width and shift cycles per block
AES_LATENCY, 10, cycles from aes_valid_o to valid aes output
MEM_START_ADDR, 1, address of the first stored word
LEN_WIDTH, 32, block-count width
SIPO_MEM_COUNT, AES_DATA_WIDTH/MEM_DATA_WIDTH, words per block (4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
len_i  in  LEN_WIDTH  number of 128-bit blocks; sampled with start
abort_i  in  1  cancel the current run
mem_rd_o  in/out: out  1  NVM read strobe
mem_addr_o  out  MEM_ADDR_WIDTH  NVM read address
mem_data_i  in  MEM_DATA_WIDTH  NVM read data, valid 1 cycle after mem_rd_o
aes_data_o  out  AES_DATA_WIDTH  assembled ciphertext block to inv_aes_128
aes_valid_o  out  1  1-cycle pulse when aes_data_o is complete
piso_load_o  out  1  1-cycle PISO parallel-load strobe
piso_en_o  out  1  PISO shift enable
sc_en_o  out  1  scan-chain enable
busy_o  out  1  high from the cycle after an accepted start until done/abort
done_o  out  1  1-cycle pulse when the run completes
err_o  out  1  1-cycle pulse when start is rejected

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, including mem_addr_o and aes_data_o. Block counter and word counter cleared. A reset in any state aborts immediately and no done_o is issued.
- States: IDLE, FETCH, CAPTURE, KICK, WAIT, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 and len_i=0 -> DONE.
  - start=1 and MEM_START_ADDR + SIPO_MEM_COUNT*len_i > 2^MEM_ADDR_WIDTH -> err_o pulse next cycle; stay IDLE; no reads. Compute this in LEN_WIDTH+MEM_ADDR_WIDTH bits with no truncation.
  - Otherwise latch len_i, set blk=0, go to FETCH.
- FETCH: 4 cycles, k=0..3.
  - mem_rd_o=1 and mem_addr_o = MEM_START_ADDR + SIPO_MEM_COUNT*blk + k.
  - The word returned for read k lands in aes_data_o[AES_DATA_WIDTH-1-32k -: 32], so word 0 is in the MSBs.
  - Data returned during FETCH is captured on the following edge.
- CAPTURE: 1 cycle. mem_rd_o=0; the last word is captured.
- KICK: 1 cycle. aes_valid_o=1. aes_data_o then holds stable until the next FETCH.
- WAIT: AES_LATENCY cycles. Outputs idle.
- LOAD: 1 cycle. piso_load_o=1.
- SHIFT: exactly AES_DATA_WIDTH cycles with piso_en_o=1 and sc_en_o=1. On the last cycle blk increments. If blk+1 < len, go to FETCH; otherwise go to DONE.
- Per-block cycle count: 4+1+1+AES_LATENCY+1+AES_DATA_WIDTH = 145 cycles at defaults.
- DONE: 1 cycle. done_o=1 and busy_o=0, then IDLE.
- busy_o=1 in FETCH..SHIFT.
- abort_i=1 in any busy state:
  - Next state is IDLE.
  - All strobes and enables drop on the next edge.
  - No done_o, and no partial shift completion.
  - abort_i has priority over every state transition.
- start while busy is ignored and not queued. start in the same cycle as DONE is ignored.
- mem_addr_o holds its last value outside FETCH.
- Counters wrap nowhere: the range check at start guarantees addresses never exceed 2^MEM_ADDR_WIDTH-1.

Decomposition:
- Shared package pmu_pkg holds the state encoding (localparam IDLE..DONE, 3 bits), the default widths shared with pmu, and the SIPO_MEM_COUNT derivation.
- One sub-module is natural: mem_block_fetcher. It covers the FETCH/CAPTURE address and word-assembly logic and outputs the 128-bit register plus a fetch_done pulse.
- The top keeps the FSM, latency counter and shift counter.

Test Plan:
- Single block: len_i=1 with NVM words 1..4 = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Required: reads at addresses 1,2,3,4.
  - aes_data_o = 0x00112233_44556677_8899AABB_CCDDEEFF when aes_valid_o fires.
  - piso_load_o 11 cycles after aes_valid_o.
  - sc_en_o high for exactly 128 cycles.
  - done_o 146 cycles after start.
- Three blocks: len_i=3.
  - Required: 12 reads at addresses 1..12 in order, 3 aes_valid_o pulses, 3 piso_load_o pulses, 384 total sc_en_o cycles.
  - busy_o continuous; a single done_o pulse.
- Zero length: len_i=0 -> done_o the cycle after start; no mem_rd_o, sc_en_o or aes_valid_o activity.
- Range reject: MEM_ADDR_WIDTH=8 with len_i=64 (needs 256 words from address 1) -> err_o pulse; busy_o stays 0; no reads.
- Mid-run abort:
  - Assert abort_i at shift cycle 50 of block 0 with len_i=2 -> sc_en_o and piso_en_o are 0 on the next edge; no done_o; no block-1 reads.
  - A new start afterwards re-reads from address 1.
- Async reset mid-FETCH: drive rst=0 between clock edges during k=2 -> all outputs 0 immediately; the first start after rst=1 runs the full sequence cleanly.
